// File: rtl/n_bit_serializer.sv
// Parallel-in, serial-out transmitter: takes one N-bit word over valid/ready and
// shifts it out one bit per clock, MSB- or LSB-first, with first/last frame strobes.
module n_bit_serializer #(
    parameter int unsigned N   = 6,
    parameter int unsigned GAP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         lsb_first,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_first,
    output logic         ser_last,
    output logic         busy
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [N-1:0]  shreg, shreg_nx;
    logic [CW-1:0] bitcnt, bitcnt_nx;
    logic [GW-1:0] gapcnt, gapcnt_nx;
    logic          dir, dir_nx;
    logic          accept;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
            dir    <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            bitcnt <= bitcnt_nx;
            gapcnt <= gapcnt_nx;
            dir    <= dir_nx;
        end
    end

    assign accept = in_valid & in_ready;

    // Next-state and datapath update; a fresh accept overrides the end-of-frame move
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        gapcnt_nx = gapcnt;
        dir_nx    = dir;
        case (state)
            S_IDLE: begin
                state_nx = S_IDLE;
            end
            S_SHIFT: begin
                shreg_nx  = dir ? {1'b0, shreg[N-1:1]} : {shreg[N-2:0], 1'b0};
                bitcnt_nx = bitcnt - CW'(1);
                if (bitcnt == '0) begin
                    bitcnt_nx = '0;
                    if (GAP > 0) begin
                        state_nx  = S_GAP;
                        gapcnt_nx = GW'(GAP);
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gapcnt <= GW'(1)) begin
                    state_nx  = S_IDLE;
                    gapcnt_nx = '0;
                end else begin
                    gapcnt_nx = gapcnt - GW'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (accept) begin
            state_nx  = S_SHIFT;
            shreg_nx  = in_data;
            dir_nx    = lsb_first;
            bitcnt_nx = CW'(N - 1);
        end
    end

    // Outputs decode purely from registered state
    assign in_ready  = (state == S_IDLE) |
                       ((state == S_SHIFT) & (bitcnt == '0) & (GAP == 0));
    assign ser_valid = (state == S_SHIFT);
    assign ser_out   = (state == S_SHIFT) ? (dir ? shreg[0] : shreg[N-1]) : 1'b0;
    assign ser_first = (state == S_SHIFT) & (bitcnt == CW'(N - 1));
    assign ser_last  = (state == S_SHIFT) & (bitcnt == '0);
    assign busy      = (state != S_IDLE);

endmodule
